// File: rtl/i2s_frame_scheduler_if.sv
// Sample handshake between the synth engine (master) and the frame scheduler (slave).
interface i2s_frame_scheduler_if #(
  parameter int W = 24
);
  logic [W-1:0] sample_l;
  logic [W-1:0] sample_r;
  logic         sample_valid;
  logic         sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_frame_scheduler.sv
// I2S frame scheduler: derives BCLK/LRCK from iAUD_XCK, buffers one stereo pair
// from the synth engine and hands it to the I2S driver once per 64-BCLK frame.
// Start/stop is frame-aligned; missing samples at the load point are counted.
module i2s_frame_scheduler #(
  parameter int AUD_BIT_DEPTH  = 24,
  parameter int MCLK_DIV       = 4,
  parameter bit UNDERRUN_MUTE  = 1'b0,
  parameter int UNDERRUN_CNT_W = 16
) (
  input  logic                     iAUD_XCK,
  input  logic                     reset_reg_N,
  input  logic                     i_enable,
  i2s_frame_scheduler_if.slave     smp,
  input  logic                     i_clr_underrun,
  output logic                     oAUD_BCLK,
  output logic                     oAUD_DACLRCK,
  output logic [AUD_BIT_DEPTH-1:0] o_lsound_out,
  output logic [AUD_BIT_DEPTH-1:0] o_rsound_out,
  output logic                     o_frame_strobe,
  output logic                     o_running,
  output logic [15:0]              o_underrun_cnt
);

  localparam int MW = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV - 1);
  localparam logic [MW-1:0] MCLK_HALF = MW'(MCLK_DIV / 2);
  localparam logic [UNDERRUN_CNT_W-1:0] UCNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_e;

  state_e                      state_q, state_d;
  logic [MW-1:0]               mclk_cnt_q, mclk_cnt_d;
  logic [5:0]                  bit_cnt_q, bit_cnt_d;
  logic                        bclk_q, bclk_d;
  logic                        lrck_q, lrck_d;
  logic                        buf_full_q, buf_full_d;
  logic [AUD_BIT_DEPTH-1:0]    buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [AUD_BIT_DEPTH-1:0]    out_l_q, out_l_d, out_r_q, out_r_d;
  logic                        strobe_q, strobe_d;
  logic [UNDERRUN_CNT_W-1:0]   ucnt_q, ucnt_d;

  logic advance, mclk_wrap, bit_wrap, load_pt, xfer, underrun;

  assign advance   = (state_q != ST_IDLE);
  assign mclk_wrap = advance && (mclk_cnt_q == MCLK_LAST);
  assign bit_wrap  = mclk_wrap && (bit_cnt_q == 6'd63);
  assign load_pt   = mclk_wrap && (bit_cnt_q == 6'd7);
  assign xfer      = smp.sample_valid && !buf_full_q;
  assign underrun  = load_pt && !buf_full_q;

  // Run/stop control: stop is deferred until the frame boundary.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_enable) state_d = ST_RUN;
      ST_RUN:  if (!i_enable) state_d = ST_STOP;
      ST_STOP: begin
        if (i_enable)      state_d = ST_RUN;
        else if (bit_wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clock dividers; BCLK/LRCK are registered from the next counter values so
  // BCLK falls exactly when bit_cnt steps and LRCK changes on a BCLK falling edge.
  always_comb begin
    mclk_cnt_d = '0;
    bit_cnt_d  = '0;
    if (advance) begin
      mclk_cnt_d = mclk_wrap ? '0 : mclk_cnt_q + MW'(1);
      bit_cnt_d  = mclk_wrap ? bit_cnt_q + 6'd1 : bit_cnt_q;
    end
    bclk_d = (mclk_cnt_d >= MCLK_HALF);
    lrck_d = bit_cnt_d[5];
  end

  // Holding buffer, output words and underrun accounting at the load point.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    out_l_d    = out_l_q;
    out_r_d    = out_r_q;
    strobe_d   = load_pt;
    ucnt_d     = ucnt_q;
    if (load_pt && buf_full_q) begin
      out_l_d    = buf_l_q;
      out_r_d    = buf_r_q;
      buf_full_d = 1'b0;
    end else if (underrun && UNDERRUN_MUTE) begin
      out_l_d = '0;
      out_r_d = '0;
    end
    // A transfer is only possible while empty, so it never collides with the buffer unload.
    if (xfer) begin
      buf_l_d    = smp.sample_l;
      buf_r_d    = smp.sample_r;
      buf_full_d = 1'b1;
    end
    if (i_clr_underrun)
      ucnt_d = '0;
    else if (underrun && (ucnt_q != UCNT_MAX))
      ucnt_d = ucnt_q + UNDERRUN_CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge iAUD_XCK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q    <= ST_IDLE;
      mclk_cnt_q <= '0;
      bit_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      buf_full_q <= 1'b0;
      // NOTE: the pair buffer is reset too; it is tiny and keeps the words driven to the DAC deterministic.
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      strobe_q   <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      mclk_cnt_q <= mclk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      strobe_q   <= strobe_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign smp.sample_ready = !buf_full_q;
  assign oAUD_BCLK        = bclk_q;
  assign oAUD_DACLRCK     = lrck_q;
  assign o_lsound_out     = out_l_q;
  assign o_rsound_out     = out_r_q;
  assign o_frame_strobe   = strobe_q;
  assign o_running        = (state_q != ST_IDLE);
  assign o_underrun_cnt   = 16'(ucnt_q);

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scoreboard bench for i2s_frame_scheduler: three instances (repeat-last,
// mute, and a 2-bit underrun counter to reach saturation quickly) share one
// stimulus stream and one frame-level reference model.
module tb_i2s_frame_scheduler;
  localparam int W = 24;

  logic xck = 1'b0;
  always #5 xck = ~xck;

  logic         rst_n = 1'b1;
  logic         en = 1'b0, clr = 1'b0, v = 1'b0;
  logic [W-1:0] dl = '0, dr = '0;

  i2s_frame_scheduler_if #(.W(W)) if0 ();
  i2s_frame_scheduler_if #(.W(W)) if1 ();
  i2s_frame_scheduler_if #(.W(W)) if2 ();
  assign if0.sample_l = dl; assign if0.sample_r = dr; assign if0.sample_valid = v;
  assign if1.sample_l = dl; assign if1.sample_r = dr; assign if1.sample_valid = v;
  assign if2.sample_l = dl; assign if2.sample_r = dr; assign if2.sample_valid = v;

  logic         bclk [3], lrck [3], stb [3], run [3], rdy [3];
  logic [W-1:0] ol [3], orr [3];
  logic [15:0]  cnt [3];
  assign rdy[0] = if0.sample_ready;
  assign rdy[1] = if1.sample_ready;
  assign rdy[2] = if2.sample_ready;

  i2s_frame_scheduler #(.AUD_BIT_DEPTH(W), .MCLK_DIV(4), .UNDERRUN_MUTE(1'b0)) u0 (
    .iAUD_XCK(xck), .reset_reg_N(rst_n), .i_enable(en), .smp(if0), .i_clr_underrun(clr),
    .oAUD_BCLK(bclk[0]), .oAUD_DACLRCK(lrck[0]), .o_lsound_out(ol[0]), .o_rsound_out(orr[0]),
    .o_frame_strobe(stb[0]), .o_running(run[0]), .o_underrun_cnt(cnt[0]));
  i2s_frame_scheduler #(.AUD_BIT_DEPTH(W), .MCLK_DIV(4), .UNDERRUN_MUTE(1'b1)) u1 (
    .iAUD_XCK(xck), .reset_reg_N(rst_n), .i_enable(en), .smp(if1), .i_clr_underrun(clr),
    .oAUD_BCLK(bclk[1]), .oAUD_DACLRCK(lrck[1]), .o_lsound_out(ol[1]), .o_rsound_out(orr[1]),
    .o_frame_strobe(stb[1]), .o_running(run[1]), .o_underrun_cnt(cnt[1]));
  i2s_frame_scheduler #(.AUD_BIT_DEPTH(W), .MCLK_DIV(4), .UNDERRUN_MUTE(1'b0), .UNDERRUN_CNT_W(2)) u2 (
    .iAUD_XCK(xck), .reset_reg_N(rst_n), .i_enable(en), .smp(if2), .i_clr_underrun(clr),
    .oAUD_BCLK(bclk[2]), .oAUD_DACLRCK(lrck[2]), .o_lsound_out(ol[2]), .o_rsound_out(orr[2]),
    .o_frame_strobe(stb[2]), .o_running(run[2]), .o_underrun_cnt(cnt[2]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level, by XCK position) ----------------
  typedef struct packed {logic bclk, lrck, run, ready, stb;} cyc_t;
  typedef struct packed {logic [W-1:0] l0, r0, l1, r1; logic [15:0] c0, c2;} frm_t;

  cyc_t cq [$];
  frm_t fq [$];

  bit           m_act, m_stop, m_full;
  int           pos, c0, c2;
  logic [W-1:0] bl, br, o0l, o0r, o1l, o1r;

  // pos = XCK edges since RUN was entered, modulo one 256-XCK frame.
  // BCLK is high in the second half of each 4-XCK period, LRCK in the second
  // half of the frame; the load point is the edge where pos reaches 32.
  always @(posedge xck) begin : model
    bit lp, xf, ur;
    cyc_t e;
    frm_t f;
    lp = 1'b0;
    ur = 1'b0;
    if (!rst_n) begin
      m_act = 0; m_stop = 0; m_full = 0; pos = 0; c0 = 0; c2 = 0;
      bl = '0; br = '0; o0l = '0; o0r = '0; o1l = '0; o1r = '0;
    end else begin
      xf = v && !m_full;
      if (m_act) begin
        lp = (pos == 31);
        if (!m_stop) begin
          if (!en) m_stop = 1;
        end else if (en) m_stop = 0;
        else if (pos == 255) m_act = 0;
        pos = m_act ? (pos + 1) % 256 : 0;
      end else if (en) begin
        m_act = 1; m_stop = 0; pos = 0;
      end
      if (lp) begin
        if (m_full) begin
          o0l = bl; o0r = br; o1l = bl; o1r = br; m_full = 0;
        end else begin
          ur = 1; o1l = '0; o1r = '0;
        end
      end
      if (xf) begin
        bl = dl; br = dr; m_full = 1;
      end
      if (clr) begin
        c0 = 0; c2 = 0;
      end else if (ur) begin
        if (c0 < 65535) c0++;
        if (c2 < 3) c2++;
      end
    end
    e.bclk  = m_act && ((pos % 4) >= 2);
    e.lrck  = m_act && (pos >= 128);
    e.run   = m_act;
    e.ready = !m_full;
    e.stb   = lp;
    cq.push_back(e);
    if (lp) begin
      f.l0 = o0l; f.r0 = o0r; f.l1 = o1l; f.r1 = o1r;
      f.c0 = 16'(c0); f.c2 = 16'(c2);
      fq.push_back(f);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge xck) begin : monitor
    cyc_t e;
    frm_t f;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      for (int i = 0; i < 3; i++)
        check($sformatf("cyc_u%0d{bclk,lrck,run,rdy,stb}", i),
              {59'd0, bclk[i], lrck[i], run[i], rdy[i], stb[i]}, {59'd0, e});
    end
    if (stb[0]) begin
      if (fq.size() == 0) begin
        check("frame_unexpected_qsize", 64'(fq.size()), 64'd1);
      end else begin
        f = fq.pop_front();
        check("frame_u0_lr", {16'd0, ol[0], orr[0]}, {16'd0, f.l0, f.r0});
        check("frame_u1_lr", {16'd0, ol[1], orr[1]}, {16'd0, f.l1, f.r1});
        check("frame_u2_lr", {16'd0, ol[2], orr[2]}, {16'd0, f.l0, f.r0});
        check("frame_u0_cnt", 64'(cnt[0]), 64'(f.c0));
        check("frame_u1_cnt", 64'(cnt[1]), 64'(f.c0));
        check("frame_u2_cnt", 64'(cnt[2]), 64'(f.c2));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge xck);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      @(negedge xck);
      n++;
    end while (!stb[0] && n < budget);
    check("strobe_seen", 64'(stb[0]), 64'd1);
    #2;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ctrl{bclk,lrck,run,stb,rdy}", {59'd0, bclk[0], lrck[0], run[0], stb[0], rdy[0]}, 64'b00001);
    check("rst_data", {16'd0, ol[0], orr[0]}, 64'd0);
    check("rst_cnt", 64'(cnt[0]), 64'd0);
    steps(4);
    rst_n = 1'b1;
    steps(3);

    // Prefill in IDLE, then start; first load point 32 XCK after RUN.
    dl = 24'h123456; dr = 24'hABCDEF; v = 1'b1;
    step();
    v = 1'b0;
    check("prefill_ready_low", 64'(rdy[0]), 64'd0);
    en = 1'b1;
    wait_strobe(64, n);
    check("first_load_latency", 64'(n), 64'd33);
    check("first_load_data", {16'd0, ol[0], orr[0]}, {16'd0, 24'h123456, 24'hABCDEF});
    check("ready_after_load", 64'(rdy[0]), 64'd1);

    // Randomized traffic, clears and enable toggles.
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 99) < 2);
      dl  = W'($urandom);
      dr  = W'($urandom);
      clr = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 799) == 0) en = ~en;
      step();
    end
    v = 1'b0; clr = 1'b0; en = 1'b1;
    wait_strobe(600, n);
    wait_strobe(600, n);

    // Known pair, then three starved frames.
    dl = 24'h0A0B0C; dr = 24'h0D0E0F; v = 1'b1;
    step();
    v = 1'b0;
    wait_strobe(300, n);
    check("known_pair", {16'd0, ol[0], orr[0]}, {16'd0, 24'h0A0B0C, 24'h0D0E0F});
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("cnt_cleared", 64'(cnt[0]), 64'd0);
    for (int k = 0; k < 3; k++) wait_strobe(300, n);
    check("underrun3_cnt_u0", 64'(cnt[0]), 64'd3);
    check("underrun3_cnt_u2", 64'(cnt[2]), 64'd3);
    check("underrun3_hold_u0", {16'd0, ol[0], orr[0]}, {16'd0, 24'h0A0B0C, 24'h0D0E0F});
    check("underrun3_mute_u1", {16'd0, ol[1], orr[1]}, 64'd0);
    wait_strobe(300, n);
    check("underrun4_cnt_u0", 64'(cnt[0]), 64'd4);
    check("saturate_cnt_u2", 64'(cnt[2]), 64'd3);

    // Clear on the same cycle as an underrun increment.
    steps(255);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_vs_inc_strobe", 64'(stb[0]), 64'd1);
    check("clr_vs_inc_u0", 64'(cnt[0]), 64'd0);
    check("clr_vs_inc_u2", 64'(cnt[2]), 64'd0);

    // Stop requested at bit_cnt 20: finish the frame, then idle.
    steps(48);
    en = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (run[0] && n < 400);
    check("stop_edges_to_idle", 64'(n), 64'd176);
    check("stop_clocks_low", {62'd0, bclk[0], lrck[0]}, 64'd0);

    // Reset mid-RUN with the buffer full.
    dl = 24'h5A5A5A; dr = 24'hA5A5A5; v = 1'b1;
    step();
    v = 1'b0;
    en = 1'b1;
    steps(10);
    check("midrun_buf_full", 64'(rdy[0]), 64'd0);
    check("midrun_running", 64'(run[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_rst_ctrl_u%0d", i),
            {59'd0, bclk[i], lrck[i], run[i], stb[i], rdy[i]}, 64'b00001);
      check($sformatf("async_rst_data_u%0d", i), {16'd0, ol[i], orr[i]}, 64'd0);
      check($sformatf("async_rst_cnt_u%0d", i), 64'(cnt[i]), 64'd0);
    end
    en = 1'b0;
    steps(3);
    rst_n = 1'b1;
    steps(2);
    check("post_rst_ready", 64'(rdy[0]), 64'd1);
    check("post_rst_idle", 64'(run[0]), 64'd0);

    steps(4);
    check("frame_queue_drained", 64'(fq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
